// File: rtl/opb_snapshot_reg_ctrl_pkg.sv
// Shared types and constants for the OPB snapshot register controller.
package opb_snap_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } snap_state_e;

  // CTRL bit positions in numeric (bit 31 = MSB) order
  localparam int CTRL_ARM_BIT   = 31;
  localparam int CTRL_CLEAR_BIT = 30;
  localparam int CTRL_DONE_BIT  = 30;
  localparam int CTRL_ARMED_BIT = 31;

  // Byte offsets inside the window
  localparam int CTRL_OFF      = 0;
  localparam int SNAP_BASE_OFF = 4;

  // Numeric bit b lands on OPB lane 31-b (OPB numbers bit 0 as the MSB).
  function automatic logic [0:31] to_opb_order(input logic [31:0] w);
    logic [0:31] r;
    for (int b = 0; b < 32; b++) r[31-b] = w[b];
    return r;
  endfunction

  function automatic logic [31:0] from_opb_order(input logic [0:31] v);
    logic [31:0] r;
    for (int b = 0; b < 32; b++) r[b] = v[31-b];
    return r;
  endfunction

endpackage

// File: rtl/opb_snapshot_reg_ctrl_if.sv
// OPB slave-side bus bundle; signals keep their OPB names and [0:n] ordering.
interface opb_bus_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [0:AW-1]   OPB_ABus;
  logic [0:DW/8-1] OPB_BE;
  logic [0:DW-1]   OPB_DBus;
  logic            OPB_RNW;
  logic            OPB_select;
  logic            OPB_seqAddr;
  logic [0:DW-1]   Sl_DBus;
  logic            Sl_errAck;
  logic            Sl_retry;
  logic            Sl_toutSup;
  logic            Sl_xferAck;

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck
  );

  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_errAck, Sl_retry, Sl_toutSup, Sl_xferAck
  );
endinterface

// File: rtl/opb_snapshot_reg_ctrl_slave.sv
// OPB slave front end: window decode, one-cycle ack pulse, read-data gating.
module opb_slave_if
  import opb_snap_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h0100_0400,
  parameter logic [31:0] C_HIGHADDR   = 32'h0100_04FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst_n,
  opb_bus_if.slave                  bus,
  output logic                      wr_en,
  output logic                      rd_en,
  output logic [C_OPB_AWIDTH-3:0]   word_off,
  output logic [C_OPB_DWIDTH-1:0]   wdata,
  output logic                      be0,
  input  logic [C_OPB_DWIDTH-1:0]   rdata
);

  logic [C_OPB_AWIDTH-1:0] addr;
  logic [C_OPB_AWIDTH-1:0] byte_off;
  logic                    in_win;
  logic                    hit;
  logic                    ack_q;
  logic [0:31]             dbus_q;
  logic                    unused_bits;

  // Address into numeric order, then window check and word offset
  always_comb begin
    addr = '0;
    for (int b = 0; b < C_OPB_AWIDTH; b++) addr[b] = bus.OPB_ABus[C_OPB_AWIDTH-1-b];
  end

  assign in_win   = (addr >= C_OPB_AWIDTH'(C_BASEADDR)) && (addr <= C_OPB_AWIDTH'(C_HIGHADDR));
  assign byte_off = addr - C_OPB_AWIDTH'(C_BASEADDR);
  assign word_off = byte_off[C_OPB_AWIDTH-1:2];

  // The ack cycle blocks decode, so a held select yields one transfer every two cycles
  assign hit   = bus.OPB_select && in_win && !ack_q;
  assign wr_en = hit && !bus.OPB_RNW;
  assign rd_en = hit && bus.OPB_RNW;
  assign wdata = from_opb_order(bus.OPB_DBus);
  assign be0   = bus.OPB_BE[0];

  assign unused_bits = ^{byte_off[1:0], bus.OPB_BE[1:3], bus.OPB_seqAddr};

  // Register the hit into the ack pulse and capture read data alongside it
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      ack_q  <= 1'b0;
      dbus_q <= '0;
    end else begin
      ack_q  <= hit;
      dbus_q <= rd_en ? to_opb_order(rdata) : '0;
    end
  end

  assign bus.Sl_xferAck = ack_q;
  assign bus.Sl_DBus    = dbus_q;
  assign bus.Sl_errAck  = 1'b0;
  assign bus.Sl_retry   = 1'b0;
  assign bus.Sl_toutSup = 1'b0;

endmodule

// File: rtl/opb_snapshot_reg_ctrl.sv
// Coherent snapshot of N user words behind one OPB window.
//   state | meaning
//   IDLE  | no capture pending
//   ARMED | next user_valid latches all words
//   DONE  | a coherent set is frozen and readable
module opb_snapshot_reg_ctrl
  import opb_snap_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h0100_0400,
  parameter logic [31:0] C_HIGHADDR   = 32'h0100_04FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          N_REGS       = 4
) (
  input  logic                OPB_Clk,
  input  logic                OPB_Rst_n,
  opb_bus_if.slave            bus,
  input  logic [N_REGS*32-1:0] user_data_in,
  input  logic                user_valid,
  output logic                snap_armed
);

  localparam int WOFF_W = C_OPB_AWIDTH - 2;

  logic                    wr_en;
  logic                    rd_en;
  logic [WOFF_W-1:0]       word_off;
  logic [C_OPB_DWIDTH-1:0] wdata;
  logic                    be0;
  logic [C_OPB_DWIDTH-1:0] rdata;

  snap_state_e state_q, state_d;
  logic [31:0] snap_q [N_REGS];
  logic [15:0] count_q;
  logic        is_ctrl;
  logic        arm_wr;
  logic        clr_wr;
  logic        capture;
  logic [31:0] ctrl_word;
  logic        unused_wdata;

  opb_slave_if #(
    .C_BASEADDR   (C_BASEADDR),
    .C_HIGHADDR   (C_HIGHADDR),
    .C_OPB_AWIDTH (C_OPB_AWIDTH),
    .C_OPB_DWIDTH (C_OPB_DWIDTH)
  ) u_slave (
    .OPB_Clk   (OPB_Clk),
    .OPB_Rst_n (OPB_Rst_n),
    .bus       (bus),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .word_off  (word_off),
    .wdata     (wdata),
    .be0       (be0),
    .rdata     (rdata)
  );

  assign is_ctrl      = (word_off == WOFF_W'(CTRL_OFF / 4));
  assign arm_wr       = wr_en && is_ctrl && be0 && wdata[CTRL_ARM_BIT];
  assign clr_wr       = wr_en && is_ctrl && be0 && wdata[CTRL_CLEAR_BIT] && !wdata[CTRL_ARM_BIT];
  assign capture      = (state_q == ARMED) && user_valid;
  assign snap_armed   = (state_q == ARMED);
  assign unused_wdata = ^wdata[CTRL_CLEAR_BIT-1:0];

  // State register
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Next state; an ARM write always wins, a CLEAR still lets a same-edge capture land
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (arm_wr) state_d = ARMED;
      ARMED: begin
        if (arm_wr)          state_d = ARMED;
        else if (clr_wr)     state_d = IDLE;
        else if (user_valid) state_d = DONE;
      end
      DONE: begin
        if (arm_wr)      state_d = ARMED;
        else if (clr_wr) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Latch every user word on the same edge so the set is coherent
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      for (int i = 0; i < N_REGS; i++) snap_q[i] <= '0;
      count_q <= '0;
    end else if (capture) begin
      for (int i = 0; i < N_REGS; i++) snap_q[i] <= user_data_in[32*i +: 32];
      count_q <= count_q + 16'd1;
    end
  end

  // Read mux; sees pre-edge values so a read at the capture edge returns the old set
  always_comb begin
    ctrl_word                 = '0;
    ctrl_word[CTRL_ARMED_BIT] = (state_q == ARMED);
    ctrl_word[CTRL_DONE_BIT]  = (state_q == DONE);
    ctrl_word[15:0]           = count_q;
    rdata = '0;
    if (rd_en) begin
      if (is_ctrl) rdata = ctrl_word;
      for (int i = 0; i < N_REGS; i++) begin
        if (word_off == WOFF_W'(SNAP_BASE_OFF / 4 + i)) rdata = snap_q[i];
      end
    end
  end

endmodule

// File: tb/tb_opb_snapshot_reg_ctrl.sv
// Directed bench for opb_snapshot_reg_ctrl: vector table plus corner sequences.
module tb_opb_snapshot_reg_ctrl;

  localparam int K_RD = 0;
  localparam int K_WR = 1;
  localparam int K_PU = 2;

  localparam logic [31:0] CTRL = 32'h0100_0400;
  localparam logic [31:0] S0   = 32'h0100_0404;
  localparam logic [31:0] S1   = 32'h0100_0408;
  localparam logic [31:0] S2   = 32'h0100_040C;
  localparam logic [31:0] S3   = 32'h0100_0410;
  localparam logic [31:0] ARM  = 32'h8000_0000;
  localparam logic [31:0] CLR  = 32'h4000_0000;

  localparam logic [127:0] SET_A = {32'hDEADBEEF, 32'h0000FFFF, 32'hA5A50001, 32'h12345678};
  localparam logic [127:0] SET_B = {32'h0BADC0DE, 32'h33334444, 32'h11112222, 32'hCAFEF00D};

  typedef struct {
    int           kind;
    logic [31:0]  addr;
    logic [3:0]   be;
    logic [31:0]  wdata;
    logic         uv;
    logic [127:0] ud;
    logic         exp_ack;
    logic [31:0]  exp_rd;
    logic         exp_armed;
  } vec_t;

  vec_t vecs[$];

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] udata = SET_A;
  logic         uv = 1'b0;
  logic         armed;
  int           tests = 0;
  int           fails = 0;

  opb_bus_if bus ();

  opb_snapshot_reg_ctrl #(.N_REGS(4)) dut (
    .OPB_Clk      (clk),
    .OPB_Rst_n    (rst_n),
    .bus          (bus),
    .user_data_in (udata),
    .user_valid   (uv),
    .snap_armed   (armed)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  task automatic add(input int kind, input logic [31:0] addr, input logic [3:0] be,
                     input logic [31:0] wd, input logic u, input logic [127:0] ud,
                     input logic eack, input logic [31:0] erd, input logic earm);
    vec_t v;
    v.kind = kind; v.addr = addr; v.be = be; v.wdata = wd; v.uv = u; v.ud = ud;
    v.exp_ack = eack; v.exp_rd = erd; v.exp_armed = earm;
    vecs.push_back(v);
  endtask

  // One bus transfer; reports the ack cycle and the cycle after it
  task automatic xfer(input logic rnw, input logic [31:0] addr, input logic [3:0] be,
                      input logic [31:0] wd, input logic u, input logic [127:0] ud,
                      output logic ack, output logic [31:0] rd,
                      output logic ack2, output logic [31:0] rd2);
    @(negedge clk);
    udata = ud;
    uv = u;
    bus.OPB_select = 1'b1;
    bus.OPB_RNW    = rnw;
    bus.OPB_ABus   = addr;
    bus.OPB_BE     = be;
    bus.OPB_DBus   = wd;
    @(posedge clk);
    #1;
    bus.OPB_select = 1'b0;
    uv = 1'b0;
    ack = bus.Sl_xferAck;
    rd  = bus.Sl_DBus;
    @(posedge clk);
    #1;
    ack2 = bus.Sl_xferAck;
    rd2  = bus.Sl_DBus;
  endtask

  task automatic pulse(input logic [127:0] ud);
    @(negedge clk);
    udata = ud;
    uv = 1'b1;
    @(posedge clk);
    #1;
    uv = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic a, a2;
    logic [31:0] d, d2;
    xfer(1'b1, addr, 4'hF, 32'h0, 1'b0, udata, a, d, a2, d2);
    check({name, " ack"}, {31'b0, a}, 32'd1);
    check({name, " data"}, d, exp);
  endtask

  task automatic wr_arm(input string name);
    logic a, a2;
    logic [31:0] d, d2;
    xfer(1'b0, CTRL, 4'hF, ARM, 1'b0, udata, a, d, a2, d2);
    check({name, " ack"}, {31'b0, a}, 32'd1);
    check({name, " armed"}, {31'b0, armed}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1);
  end

  initial begin
    logic a, a2;
    logic [31:0] d, d2;
    logic [3:0] ack_seq;
    logic [31:0] dat_seq [4];

    bus.OPB_select  = 1'b0;
    bus.OPB_RNW     = 1'b1;
    bus.OPB_ABus    = '0;
    bus.OPB_BE      = '0;
    bus.OPB_DBus    = '0;
    bus.OPB_seqAddr = 1'b0;

    //   kind  addr          be    wdata         uv ud     ack exp_rd          armed
    add(K_RD, CTRL,         4'hF, 32'h0,        0, SET_A, 1, 32'h0000_0000, 0);
    add(K_RD, S0,           4'hF, 32'h0,        0, SET_A, 1, 32'h0000_0000, 0);
    add(K_WR, CTRL,         4'hF, ARM,          0, SET_A, 1, 32'h0,         1);
    add(K_PU, 0,            4'h0, 32'h0,        1, SET_A, 0, 32'h0,         0);
    add(K_RD, CTRL,         4'hF, 32'h0,        0, SET_A, 1, 32'h4000_0001, 0);
    add(K_RD, S0,           4'hF, 32'h0,        0, SET_A, 1, 32'h1234_5678, 0);
    add(K_RD, S1,           4'hF, 32'h0,        0, SET_A, 1, 32'hA5A5_0001, 0);
    add(K_RD, S2,           4'hF, 32'h0,        0, SET_A, 1, 32'h0000_FFFF, 0);
    add(K_RD, S3,           4'hF, 32'h0,        0, SET_A, 1, 32'hDEAD_BEEF, 0);
    add(K_PU, 0,            4'h0, 32'h0,        1, SET_B, 0, 32'h0,         0);
    add(K_RD, S0,           4'hF, 32'h0,        0, SET_B, 1, 32'h1234_5678, 0);
    add(K_RD, S3,           4'hF, 32'h0,        0, SET_B, 1, 32'hDEAD_BEEF, 0);
    add(K_WR, S0,           4'hF, 32'hFFFF_FFFF,0, SET_B, 1, 32'h0,         0);
    add(K_RD, S0,           4'hF, 32'h0,        0, SET_B, 1, 32'h1234_5678, 0);
    add(K_WR, CTRL,         4'hF, ARM,          0, SET_B, 1, 32'h0,         1);
    add(K_RD, S0,           4'hF, 32'h0,        0, SET_B, 1, 32'h1234_5678, 1);
    add(K_PU, 0,            4'h0, 32'h0,        1, SET_B, 0, 32'h0,         0);
    add(K_RD, CTRL,         4'hF, 32'h0,        0, SET_B, 1, 32'h4000_0002, 0);
    add(K_RD, S0,           4'hF, 32'h0,        0, SET_B, 1, 32'hCAFE_F00D, 0);
    add(K_RD, S3,           4'hF, 32'h0,        0, SET_B, 1, 32'h0BAD_C0DE, 0);
    add(K_WR, CTRL,         4'hF, CLR,          0, SET_B, 1, 32'h0,         0);
    add(K_RD, CTRL,         4'hF, 32'h0,        0, SET_B, 1, 32'h0000_0002, 0);
    add(K_RD, S0,           4'hF, 32'h0,        0, SET_B, 1, 32'hCAFE_F00D, 0);
    add(K_WR, CTRL,         4'h7, ARM,          0, SET_B, 1, 32'h0,         0);
    add(K_RD, CTRL,         4'hF, 32'h0,        0, SET_B, 1, 32'h0000_0002, 0);
    add(K_RD, 32'h0100_0480,4'hF, 32'h0,        0, SET_B, 1, 32'h0,         0);
    add(K_RD, 32'h0100_0500,4'hF, 32'h0,        0, SET_B, 0, 32'h0,         0);
    add(K_WR, 32'h0100_0500,4'hF, ARM,          0, SET_B, 0, 32'h0,         0);
    add(K_RD, 32'h0100_0414,4'hF, 32'h0,        0, SET_B, 1, 32'h0,         0);
    add(K_WR, CTRL,         4'hF, ARM,          1, SET_A, 1, 32'h0,         1);
    add(K_RD, CTRL,         4'hF, 32'h0,        0, SET_A, 1, 32'h8000_0002, 1);
    add(K_RD, S0,           4'hF, 32'h0,        0, SET_A, 1, 32'hCAFE_F00D, 1);
    add(K_PU, 0,            4'h0, 32'h0,        1, SET_A, 0, 32'h0,         0);
    add(K_RD, CTRL,         4'hF, 32'h0,        0, SET_A, 1, 32'h4000_0003, 0);
    add(K_RD, S0,           4'hF, 32'h0,        0, SET_A, 1, 32'h1234_5678, 0);
    add(K_WR, CTRL,         4'hF, 32'hC000_0000,0, SET_A, 1, 32'h0,         1);
    add(K_WR, CTRL,         4'hF, CLR,          1, SET_B, 1, 32'h0,         0);
    add(K_RD, CTRL,         4'hF, 32'h0,        0, SET_B, 1, 32'h0000_0004, 0);
    add(K_RD, S0,           4'hF, 32'h0,        0, SET_B, 1, 32'hCAFE_F00D, 0);
    add(K_WR, CTRL,         4'hF, CLR,          0, SET_B, 1, 32'h0,         0);
    add(K_PU, 0,            4'h0, 32'h0,        1, SET_A, 0, 32'h0,         0);
    add(K_RD, CTRL,         4'hF, 32'h0,        0, SET_A, 1, 32'h0000_0004, 0);
    add(K_RD, S0,           4'hF, 32'h0,        0, SET_A, 1, 32'hCAFE_F00D, 0);
    add(K_WR, CTRL,         4'hF, ARM,          0, SET_A, 1, 32'h0,         1);
    add(K_RD, S0,           4'hF, 32'h0,        1, SET_A, 1, 32'hCAFE_F00D, 0);
    add(K_RD, S0,           4'hF, 32'h0,        0, SET_A, 1, 32'h1234_5678, 0);
    add(K_RD, CTRL,         4'hF, 32'h0,        0, SET_A, 1, 32'h4000_0005, 0);
    add(K_WR, CTRL,         4'h8, ARM,          0, SET_A, 1, 32'h0,         1);
    add(K_WR, CTRL,         4'hF, CLR,          0, SET_A, 1, 32'h0,         0);
    add(K_RD, CTRL,         4'hF, 32'h0,        0, SET_A, 1, 32'h0000_0005, 0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset armed", {31'b0, armed}, 32'd0);
    check("reset ack", {31'b0, bus.Sl_xferAck}, 32'd0);
    check("reset dbus", bus.Sl_DBus, 32'd0);
    check("tied outputs", {29'b0, bus.Sl_errAck, bus.Sl_retry, bus.Sl_toutSup}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Vector table
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].kind == K_PU) begin
        pulse(vecs[i].ud);
      end else begin
        xfer(vecs[i].kind == K_RD, vecs[i].addr, vecs[i].be, vecs[i].wdata,
             vecs[i].uv, vecs[i].ud, a, d, a2, d2);
        check($sformatf("v%0d ack", i), {31'b0, a}, {31'b0, vecs[i].exp_ack});
        check($sformatf("v%0d data", i), d, vecs[i].exp_rd);
        check($sformatf("v%0d idle bus", i), d2 | {31'b0, a2}, 32'd0);
      end
      check($sformatf("v%0d armed", i), {31'b0, armed}, {31'b0, vecs[i].exp_armed});
    end

    // Held select: one transfer every two cycles, Sl_DBus zero between acks
    @(negedge clk);
    bus.OPB_select = 1'b1;
    bus.OPB_RNW    = 1'b1;
    bus.OPB_ABus   = CTRL;
    bus.OPB_BE     = 4'hF;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      ack_seq[c] = bus.Sl_xferAck;
      dat_seq[c] = bus.Sl_DBus;
    end
    bus.OPB_select = 1'b0;
    check("b2b ack pattern", {28'b0, ack_seq}, 32'h0000_0005);
    check("b2b data c0", dat_seq[0], 32'h0000_0005);
    check("b2b data c1", dat_seq[1], 32'h0);
    check("b2b data c2", dat_seq[2], 32'h0000_0005);
    check("b2b data c3", dat_seq[3], 32'h0);

    // snap_count wrap 0xFFFF -> 0
    @(negedge clk);
    force dut.count_q = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.count_q;
    rd_check("wrap pre", CTRL, 32'h0000_FFFF);
    wr_arm("wrap arm");
    pulse(SET_B);
    rd_check("wrap post", CTRL, 32'h4000_0000);

    // Reset during the ack cycle
    wr_arm("rst arm");
    @(negedge clk);
    bus.OPB_select = 1'b1;
    bus.OPB_RNW    = 1'b1;
    bus.OPB_ABus   = CTRL;
    @(posedge clk);
    #1;
    bus.OPB_select = 1'b0;
    check("rst pre ack", {31'b0, bus.Sl_xferAck}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst ack drop", {31'b0, bus.Sl_xferAck}, 32'd0);
    check("rst dbus", bus.Sl_DBus, 32'd0);
    check("rst armed", {31'b0, armed}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rd_check("rst ctrl", CTRL, 32'h0);
    rd_check("rst snap0", S0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
